// File: rtl/fetch_ctrl.sv
// Instruction-fetch PC controller: boot, sequential advance, branch/jump redirect, stall and halt.
// Optional fetch counter output enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        brTaken,
  input  logic        jumpTaken,
  input  logic [31:0] NewPC,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] adderOut,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign,
  output logic [1:0]  state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2, HALT = 2'd3} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_pend_valid;
  logic        w_pend_valid_next;
  logic [31:0] r_pend_pc;
  logic [31:0] w_pend_pc_next;
  logic        w_redirect;
  logic        w_active;
  logic [31:0] w_target;

  assign w_redirect = brTaken | jumpTaken;
  assign w_target   = {NewPC[31:2], 2'b00};
  assign w_active   = (r_state == RUN) || (r_state == STALL);
  assign pc         = r_pc;
  assign adderOut   = r_pc + 32'(PC_STEP);
  assign state      = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= BOOT;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT:      w_next_state = RUN;
      RUN,
      STALL:     w_next_state = halt ? HALT : (stall ? STALL : RUN);
      default:   w_next_state = HALT;
    endcase
  end

  // halt wins over redirect, so a halting cycle never flushes
  always_comb begin
    fetch_valid = (r_state == RUN);
    flush       = w_active && w_redirect && !halt;
    misalign    = flush && (NewPC[1:0] != 2'b00);
  end

  always_comb begin
    w_pc_next         = r_pc;
    w_pend_valid_next = r_pend_valid;
    w_pend_pc_next    = r_pend_pc;
    if (w_active && halt) begin
      w_pend_valid_next = 1'b0;
    end else if (r_state == RUN) begin
      if (w_redirect && stall) begin
        w_pend_valid_next = 1'b1;
        w_pend_pc_next    = w_target;
      end else if (w_redirect) begin
        w_pc_next = w_target;
      end else if (!stall) begin
        w_pc_next = adderOut;
      end
    end else if (r_state == STALL) begin
      if (stall) begin
        if (w_redirect) begin
          w_pend_valid_next = 1'b1;
          w_pend_pc_next    = w_target;
        end
      end else begin
        // a redirect arriving in the release cycle is the latest target
        if (w_redirect)        w_pc_next = w_target;
        else if (r_pend_valid) w_pc_next = r_pend_pc;
        w_pend_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'h0;
    end else begin
      r_pc         <= w_pc_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_pc    <= w_pend_pc_next;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         r_fetch_count <= 32'h0;
    else if (fetch_valid && r_fetch_count != '1)      r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter PC_STEP, default 4, the sequential PC increment in bytes.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-005 Port stall SHALL be input, 1 bit: hazard unit holds the PC.
REQ-006 Port brTaken SHALL be input, 1 bit: branch resolved taken, redirect to NewPC.
REQ-007 Port jumpTaken SHALL be input, 1 bit: jump decoded, redirect to NewPC.
REQ-008 Port NewPC SHALL be input, 32 bits: redirect target.
REQ-009 Port halt SHALL be input, 1 bit: stop fetching permanently.
REQ-010 Port pc SHALL be output, 32 bits: current fetch address to the PC register and instruction memory.
REQ-011 Port adderOut SHALL be output, 32 bits: pc + PC_STEP, modulo 2^32.
REQ-012 Port fetch_valid SHALL be output, 1 bit: the instruction at pc is a real fetch.
REQ-013 Port flush SHALL be output, 1 bit: kill the instruction currently in IF/ID.
REQ-014 Port misalign SHALL be output, 1 bit: one-cycle pulse when a redirect target has NewPC[1:0] != 0.
REQ-015 Port state SHALL be output, 2 bits: FSM state encoding.

Function
REQ-016 The FSM SHALL have states BOOT=0, RUN=1, STALL=2 and HALT=3.
REQ-017 BOOT SHALL last exactly one cycle after reset release, with fetch_valid=0 and pc=RESET_PC; then RUN.
REQ-018 In RUN, with no stall, redirect or halt, pc SHALL advance by PC_STEP each cycle; 32'hFFFF_FFFC wraps to 0; fetch_valid=1.
REQ-019 Redirect SHALL mean brTaken|jumpTaken; both use NewPC, and brTaken==jumpTaken==1 is one redirect.
REQ-020 A redirect in RUN SHALL set flush=1 combinationally in that cycle and load pc <= {NewPC[31:2],2'b00} at the next edge (one-cycle redirect latency).
REQ-021 Redirect SHALL take priority over stall; a redirect in the same cycle as stall SHALL set flush=1, latch the target in a pending register and enter STALL.
REQ-022 stall in RUN without redirect SHALL enter STALL; pc SHALL be held and fetch_valid=0 while in STALL.
REQ-023 A redirect during STALL SHALL overwrite the pending target (latest wins) and assert flush.
REQ-024 On stall deassertion in STALL, pc SHALL load the pending target if one is valid, otherwise hold; the pending flag SHALL then clear and the FSM return to RUN.
REQ-025 halt in RUN or STALL SHALL enter HALT at the next edge; halt has priority over stall and redirect in that cycle. Any pending target SHALL be discarded.
REQ-026 In HALT, pc SHALL be frozen, fetch_valid=0 and flush=0, and all inputs SHALL be ignored; HALT is exited only by reset.
REQ-027 misalign SHALL pulse together with flush for a misaligned redirect; the target is force-aligned and no other action is taken.

Reset
REQ-028 Asserting rst (0) SHALL immediately force state=BOOT, pc=RESET_PC, fetch_valid=0, flush=0, misalign=0 and pending cleared, including mid-stall and mid-redirect.
REQ-029 adderOut SHALL equal RESET_PC+PC_STEP during reset.

Configuration
REQ-030 When FETCH_CTRL_PERF_EN is defined, the block SHALL add output fetch_count (32 bits, reset 0), which increments on every cycle with fetch_valid=1 and saturates at 32'hFFFF_FFFF.
REQ-031 When FETCH_CTRL_PERF_EN is undefined, the fetch_count port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset release, no inputs for 4 cycles -> pc 0 (BOOT), 0, 4, 8; fetch_valid 0,1,1,1.
REQ-033 brTaken=1 with NewPC=32'h40 at pc=8 -> flush=1 that cycle, pc=32'h40 next, then 32'h44.
REQ-034 stall plus jumpTaken with NewPC=32'h80 at pc=12, stall held 3 cycles -> pc frozen at 12 with fetch_valid=0; after release pc=32'h80 and state RUN.
REQ-035 Redirect with NewPC=32'h102 -> misalign pulse for 1 cycle, pc=32'h100.
REQ-036 pc=32'hFFFF_FFFC, no events -> next pc=0, and adderOut=4 after the wrap.
REQ-037 halt at pc=32'h20, then brTaken pulses -> pc stays 32'h20, fetch_valid=0; rst low mid-HALT -> pc=RESET_PC asynchronously (fetch_count=0 with FETCH_CTRL_PERF_EN).
